// File: rtl/regs_pkg.sv
// regs_pkg: shared constants for the architectural register file.
//   ZERO_WORD     all-zero 32-bit data word
//   ZERO_REG      register index of x0, the hardwired-zero register
//   REG_NUM       number of architectural integer registers
//   regs_state_e  clear-sequencer state (REGS_ST_CLEAR / REGS_ST_RUN)
package regs_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [4:0]  ZERO_REG  = 5'h0;
  localparam int          REG_NUM   = 32;

  typedef enum logic {
    REGS_ST_CLEAR = 1'b0,
    REGS_ST_RUN   = 1'b1
  } regs_state_e;

endpackage

// File: rtl/regs.sv
// regs: architectural integer register file x0..x31.
//
// One write port, driven by the execute stage. Two combinational read ports
// serve the decode stage. After reset, a sequencer zeroes x1..x31, one entry
// per cycle. The array has no reset of its own, so it can map onto distributed
// or block RAM. x0 reads as zero and is never written.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           synchronous reset, active-low
//   reg1_raddr_i  read port 1 address (rs1)
//   reg2_raddr_i  read port 2 address (rs2)
//   reg1_rdata_o  read port 1 data, combinational
//   reg2_rdata_o  read port 2 data, combinational
//   reg_waddr_i   write address (execute rd_addr_o)
//   reg_wdata_i   write data    (execute rd_data_o)
//   reg_wen_i     write enable  (execute rd_wen_o)
//   busy_o        high while the clear sequencer runs; the pipeline must stall
//
// Build option:
//   REGS_BYPASS_EN  when defined, a same-cycle write to a read address is
//                   forwarded to that read port (write-first). Forwarding is
//                   applied per port, only in RUN, and never for x0.
module regs
  import regs_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = REG_NUM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] reg1_raddr_i,
  input  logic [AW-1:0] reg2_raddr_i,
  output logic [DW-1:0] reg1_rdata_o,
  output logic [DW-1:0] reg2_rdata_o,
  input  logic [AW-1:0] reg_waddr_i,
  input  logic [DW-1:0] reg_wdata_i,
  input  logic          reg_wen_i,
  output logic          busy_o
);

  regs_state_e   state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  // Single write port into the array, shared by the clear sequencer and the
  // execute stage.
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Entry 0 is never written or read; x0 is synthesised as a constant zero.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= REGS_ST_CLEAR;
      clr_ptr_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = reg_waddr_i;
    mem_wdata = reg_wdata_i;
    case (state_q)
      REGS_ST_CLEAR: begin
        // Execute-stage writes are dropped while clearing.
        mem_we    = rst;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        // Leave at x31, so the pointer never wraps back to x0.
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = REGS_ST_RUN;
        end
      end
      REGS_ST_RUN: begin
        mem_we = rst && reg_wen_i && (reg_waddr_i != ZERO_REG);
      end
      default: begin
        state_d = REGS_ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy_o = (state_q == REGS_ST_CLEAR);

  always_comb begin
    reg1_rdata_o = '0;
    if ((state_q == REGS_ST_RUN) && (reg1_raddr_i != ZERO_REG)) begin
`ifdef REGS_BYPASS_EN
      if (reg_wen_i && (reg_waddr_i == reg1_raddr_i)) begin
        reg1_rdata_o = reg_wdata_i;
      end else begin
        reg1_rdata_o = mem_q[reg1_raddr_i];
      end
`else
      reg1_rdata_o = mem_q[reg1_raddr_i];
`endif
    end
  end

  always_comb begin
    reg2_rdata_o = '0;
    if ((state_q == REGS_ST_RUN) && (reg2_raddr_i != ZERO_REG)) begin
`ifdef REGS_BYPASS_EN
      if (reg_wen_i && (reg_waddr_i == reg2_raddr_i)) begin
        reg2_rdata_o = reg_wdata_i;
      end else begin
        reg2_rdata_o = mem_q[reg2_raddr_i];
      end
`else
      reg2_rdata_o = mem_q[reg2_raddr_i];
`endif
    end
  end

endmodule

// File: tb/tb_regs.sv
// tb_regs: directed self-checking bench for the regs register file.
module tb_regs;

  logic        clk;
  logic        rst;
  logic [4:0]  reg1_raddr_i;
  logic [4:0]  reg2_raddr_i;
  logic [31:0] reg1_rdata_o;
  logic [31:0] reg2_rdata_o;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_wen_i;
  logic        busy_o;

  int total;
  int bad;

  regs dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_raddr_i (reg1_raddr_i),
    .reg2_raddr_i (reg2_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_rdata_o (reg2_rdata_o),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wen_i    (reg_wen_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wen_i   = 1'b1;
    reg_waddr_i = a;
    reg_wdata_i = d;
    step();
    reg_wen_i   = 1'b0;
  endtask

  // Runs the clear sequence while busy is high. Port 1 must read 0 every
  // cycle. At busy cycle wr_at, a write of wd to wa is offered, and the
  // design must drop it. The sequence must last exactly 31 cycles.
  task automatic run_clear(input logic [4:0] rd_a, input int wr_at,
                           input logic [4:0] wa, input logic [31:0] wd);
    int cycles;
    cycles = 0;
    reg1_raddr_i = rd_a;
    while (busy_o === 1'b1 && cycles < 100) begin
      #1;
      check("clr_read", reg1_rdata_o, 32'h0);
      reg_wen_i   = (cycles == wr_at);
      reg_waddr_i = wa;
      reg_wdata_i = wd;
      step();
      cycles++;
    end
    reg_wen_i = 1'b0;
    check("busy_len", 32'(cycles), 32'd31);
    #1;
    check("busy_low", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    reg1_raddr_i = 5'd0;
    reg2_raddr_i = 5'd0;
    reg_waddr_i  = 5'd0;
    reg_wdata_i  = 32'h0;
    reg_wen_i    = 1'b0;

    // Hold reset for three cycles, then release.
    repeat (3) step();
    check("rst_busy", {31'h0, busy_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("rel_busy", {31'h0, busy_o}, 32'h1);
    // Port 1 watches x5. The write to x9 lands on the 5th busy cycle.
    run_clear(5'd5, 4, 5'd9, 32'hAA);
    reg1_raddr_i = 5'd5;
    #1;
    check("x5_after", reg1_rdata_o, 32'h0);
    reg1_raddr_i = 5'd9;
    #1;
    check("x9_after_clr", reg1_rdata_o, 32'h0);

    // Basic write, then read on both ports.
    wr(5'd7, 32'hDEADBEEF);
    reg1_raddr_i = 5'd7;
    reg2_raddr_i = 5'd7;
    #1;
    check("x7_p1", reg1_rdata_o, 32'hDEADBEEF);
    check("x7_p2", reg2_rdata_o, 32'hDEADBEEF);

    // Writes to x0 are discarded.
    wr(5'd0, 32'h12345678);
    reg1_raddr_i = 5'd0;
    reg2_raddr_i = 5'd0;
    #1;
    check("x0_p1", reg1_rdata_o, 32'h0);
    check("x0_p2", reg2_rdata_o, 32'h0);

    // x0 stays 0 even while being written in the same cycle.
    reg_wen_i   = 1'b1;
    reg_waddr_i = 5'd0;
    reg_wdata_i = 32'hFFFFFFFF;
    #1;
    check("x0_samecyc", reg1_rdata_o, 32'h0);
    step();
    reg_wen_i = 1'b0;

    // Same-cycle read and write of x3. Port 2 reads an unrelated register.
    wr(5'd3, 32'h1);
    reg1_raddr_i = 5'd3;
    reg2_raddr_i = 5'd7;
    reg_wen_i    = 1'b1;
    reg_waddr_i  = 5'd3;
    reg_wdata_i  = 32'h2;
    #1;
`ifdef REGS_BYPASS_EN
    check("hazard_now", reg1_rdata_o, 32'h2);
`else
    check("hazard_now", reg1_rdata_o, 32'h1);
`endif
    check("hazard_p2", reg2_rdata_o, 32'hDEADBEEF);
    step();
    reg_wen_i = 1'b0;
    #1;
    check("hazard_next", reg1_rdata_o, 32'h2);

    // Fill x1..x4, then pulse reset mid-run.
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'hA0000000 | 32'(i));
    reg2_raddr_i = 5'd4;
    #1;
    check("x4_filled", reg2_rdata_o, 32'hA0000004);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rst2_busy", {31'h0, busy_o}, 32'h1);
    // During this clear, x1 must already read 0. The late write to x9 lands
    // after x9 has been cleared, so it would persist if it were not dropped.
    run_clear(5'd1, 20, 5'd9, 32'h55);
    for (int i = 1; i <= 4; i++) begin
      reg1_raddr_i = 5'(i);
      #1;
      check("x1to4_zero", reg1_rdata_o, 32'h0);
    end
    reg2_raddr_i = 5'd9;
    #1;
    check("x9_late_drop", reg2_rdata_o, 32'h0);
    reg2_raddr_i = 5'd7;
    #1;
    check("x7_rezero", reg2_rdata_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regs.md
Name: regs

Overview:
- Architectural integer register file, x0..x31, 32 bits wide.
- Sits directly downstream of the execute stage: it consumes the execute stage's rd_addr/rd_data/rd_wen as its write port.
- Serves the decode stage through two combinational read ports; those read values become op1/op2 for execute.
- A post-reset clear sequencer zeroes the array one entry per cycle, so it maps onto FPGA distributed/block RAM.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width.
- DEPTH, 32, number of registers (equals 2**AW).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low.
- reg1_raddr_i  input  AW  read port 1 address (rs1).
- reg2_raddr_i  input  AW  read port 2 address (rs2).
- reg1_rdata_o  output  DW  read port 1 data, combinational.
- reg2_rdata_o  output  DW  read port 2 data, combinational.
- reg_waddr_i  input  AW  write address, from the execute stage's rd_addr_o.
- reg_wdata_i  input  DW  write data, from the execute stage's rd_data_o.
- reg_wen_i  input  1  write enable, from the execute stage's rd_wen_o.
- busy_o  output  1  high while the clear sequencer runs; the pipeline must stall while it is high.

Behaviour:
- Reset: clk and a single synchronous, active-low reset rst.
  - rst==0 sampled at posedge: state<=CLEAR, clr_ptr<=1, busy_o<=1.
  - Array contents are not touched directly by reset.
- State CLEAR:
  - Each posedge with rst==1 writes mem[clr_ptr]<=0 and increments clr_ptr.
  - At the posedge that clears x31, state<=RUN and busy_o<=0.
  - busy_o is therefore high for exactly 31 posedges after reset release.
- CLEAR side effects:
  - reg_wen_i is ignored; the write is dropped.
  - Both read ports return 0.
- State RUN: at posedge, if reg_wen_i==1 and reg_waddr_i!=0, mem[reg_waddr_i]<=reg_wdata_i.
- x0 rules:
  - Writes to address 0 are discarded in all states.
  - Reads of address 0 return 0 in all states.
  - mem[0] is never read.
- Reads:
  - Purely combinational; zero-cycle latency from address to data.
  - Both ports are independent and may address the same register.
- Simultaneous read and write to the same non-zero address in RUN, without bypass: read returns the pre-write value; the new value is visible from the next cycle.
- Reset mid-CLEAR or mid-RUN: restarts the sequence from clr_ptr=1. All registers are re-zeroed before busy_o drops.
- No arithmetic beyond clr_ptr increment (AW bits); the pointer never wraps because the FSM leaves CLEAR at 31.
- FSM is two states, CLEAR and RUN, encoded as 1 bit.
- Only exits:
  - CLEAR to RUN on clr_ptr==DEPTH-1 && rst.
  - any state to CLEAR on !rst.

Optional Feature:
- Macro: REGS_BYPASS_EN.
- Defined: write-first forwarding. In RUN, if reg_wen_i==1, reg_waddr_i!=0 and reg_waddr_i==regN_raddr_i, then regN_rdata_o=reg_wdata_i in the same cycle. This applies per port independently.
- Undefined: no forwarding; read-during-write returns the old value, as above.
- Forwarding never applies during CLEAR or to x0.

Decomposition:
- Shared defines file, alongside the existing opcode/func3 constants, gets:
  - ZERO_WORD (32'h0)
  - ZERO_REG (5'h0)
  - REG_NUM (32)
  - REGS_ST_CLEAR / REGS_ST_RUN state encodings
- No sub-module; the clear FSM and array are small enough to stay inline in regs.

Test Plan:
- Clear timing: hold rst=0 for 3 cycles, release -> busy_o=1 for exactly 31 posedges, then 0. A read of x5 returns 0 throughout and after.
- Write/read in RUN: write x7=32'hDEADBEEF; next cycle read reg1=x7, reg2=x7 -> both 32'hDEADBEEF.
- x0 guard: write x0=32'h12345678 -> read x0 returns 0.
- Same-cycle hazard: x3 holds 32'h1, write x3=32'h2 while reading x3. Without REGS_BYPASS_EN -> 32'h1 that cycle and 32'h2 the next. With REGS_BYPASS_EN -> 32'h2 that cycle.
- Write during CLEAR: reg_wen_i=1, x9=32'hAA on the 5th cycle after reset release -> after busy_o falls, x9 reads 0.
- Reset mid-operation: fill x1..x4 with nonzero values, pulse rst=0 for 1 cycle -> busy_o high for 31 cycles again, and x1..x4 read 0 afterwards.
